// File: rtl/ctrl_pkg.sv
// Shared opcode, state, ALUOp and PCSrc encodings for the multi-cycle
// MIPS-subset control unit and its datapath.
package ctrl_pkg;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLT  = 6'b011000;
  localparam logic [5:0] OP_SW   = 6'b100110;
  localparam logic [5:0] OP_LW   = 6'b100111;
  localparam logic [5:0] OP_BEQ  = 6'b110000;
  localparam logic [5:0] OP_BNE  = 6'b110001;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b111
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b110;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  typedef enum logic [2:0] {
    C_ALU,
    C_LW,
    C_SW,
    C_BR,
    C_J,
    C_HALT,
    C_BAD
  } op_class_t;

  typedef struct packed {
    logic       pc_wre;
    logic       ir_wre;
    logic       ext_sel;
    logic       alu_src_b;
    logic [2:0] alu_op;
    logic       reg_dst;
    logic       reg_wre;
    logic       db_data_src;
    logic       m_rd;
    logic       m_wr;
    logic [1:0] pc_src;
  } ctrl_t;

  function automatic op_class_t op_class(input logic [5:0] op);
    op_class_t c;
    unique case (op)
      OP_ADD, OP_SUB, OP_ADDI,
      OP_OR, OP_AND, OP_ORI,
      OP_SLT:         c = C_ALU;
      OP_LW:          c = C_LW;
      OP_SW:          c = C_SW;
      OP_BEQ, OP_BNE: c = C_BR;
      OP_J:           c = C_J;
      OP_HALT:        c = C_HALT;
      default:        c = C_BAD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational map from (state, opcode, zero) to the datapath control
// bundle; run low suppresses every enable.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic           run,
  input  state_t         state,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  output ctrl_t          ctrl
);

  op_class_t cls;
  logic      taken;

  assign cls   = op_class(opcode);
  assign taken = (opcode == OP_BEQ && zero) ||
                 (opcode == OP_BNE && !zero);

  always_comb begin
    ctrl         = '0;
    ctrl.ext_sel = 1'b1;
    ctrl.alu_op  = ALU_ADD;
    ctrl.pc_src  = PC_SEQ;

    unique case (opcode)
      OP_ADD: ctrl.reg_dst = 1'b1;
      OP_SUB: begin
        ctrl.reg_dst = 1'b1;
        ctrl.alu_op  = ALU_SUB;
      end
      OP_ADDI: ctrl.alu_src_b = 1'b1;
      OP_OR: begin
        ctrl.reg_dst = 1'b1;
        ctrl.alu_op  = ALU_OR;
        ctrl.ext_sel = 1'b0;
      end
      OP_AND: begin
        ctrl.reg_dst = 1'b1;
        ctrl.alu_op  = ALU_AND;
        ctrl.ext_sel = 1'b0;
      end
      OP_ORI: begin
        ctrl.alu_src_b = 1'b1;
        ctrl.alu_op    = ALU_OR;
        ctrl.ext_sel   = 1'b0;
      end
      OP_SLT: begin
        ctrl.reg_dst = 1'b1;
        ctrl.alu_op  = ALU_SLT;
      end
      OP_SW: ctrl.alu_src_b = 1'b1;
      OP_LW: begin
        ctrl.alu_src_b   = 1'b1;
        ctrl.db_data_src = 1'b1;
      end
      OP_BEQ, OP_BNE: ctrl.alu_op = ALU_SUB;
      default: ;
    endcase

    // PC advances only in the last phase of each instruction
    unique case (1'b1)
      state == S_IF: ctrl.ir_wre = 1'b1;
      state == S_ID:
        ctrl.pc_wre = (cls == C_J) || (cls == C_BAD);
      state == S_EXE: begin
        ctrl.pc_wre = (cls == C_BR);
        if (taken) ctrl.pc_src = PC_BR;
      end
      state == S_MEM: begin
        ctrl.pc_wre = (cls == C_SW);
        ctrl.m_rd   = (cls == C_LW);
        ctrl.m_wr   = (cls == C_SW);
      end
      state == S_WB: begin
        ctrl.pc_wre  = 1'b1;
        ctrl.reg_wre = 1'b1;
      end
      default: ;
    endcase

    if (cls == C_J) ctrl.pc_src = PC_JMP;

    if (!run) begin
      ctrl.pc_wre  = 1'b0;
      ctrl.ir_wre  = 1'b0;
      ctrl.reg_wre = 1'b0;
      ctrl.m_rd    = 1'b0;
      ctrl.m_wr    = 1'b0;
      ctrl.pc_src  = PC_SEQ;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit: instruction phase register and next-state
// logic; all controls come from ctrl_decode.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int OPW    = 6,
  parameter int ALUOPW = 3
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [OPW-1:0]    opcode,
  input  logic              zero,
  output logic              PCWre,
  output logic              IRWre,
  output logic              ExtSel,
  output logic              ALUSrcB,
  output logic [ALUOPW-1:0] ALUOp,
  output logic              RegDst,
  output logic              RegWre,
  output logic              DBDataSrc,
  output logic              mRD,
  output logic              mWR,
  output logic [1:0]        PCSrc,
  output logic [2:0]        state
);

  state_t    st;
  state_t    st_nxt;
  op_class_t cls;
  ctrl_t     ctrl;

  assign cls = op_class(opcode);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) st <= S_IF;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt = S_IF;
    unique case (st)
      S_IF: st_nxt = S_ID;
      S_ID: begin
        if (cls == C_HALT)
          st_nxt = S_HALT;
        else if (cls == C_J || cls == C_BAD)
          st_nxt = S_IF;
        else
          st_nxt = S_EXE;
      end
      S_EXE: begin
        if (cls == C_BR)
          st_nxt = S_IF;
        else if (cls == C_LW || cls == C_SW)
          st_nxt = S_MEM;
        else
          st_nxt = S_WB;
      end
      S_MEM:
        st_nxt = (cls == C_LW) ? S_WB : S_IF;
      S_WB:   st_nxt = S_IF;
      S_HALT: st_nxt = S_HALT;
      default: st_nxt = S_IF;
    endcase
  end

  ctrl_decode #(
    .OPW(OPW)
  ) u_decode (
    .run   (Reset),
    .state (st),
    .opcode(opcode),
    .zero  (zero),
    .ctrl  (ctrl)
  );

  assign PCWre     = ctrl.pc_wre;
  assign IRWre     = ctrl.ir_wre;
  assign ExtSel    = ctrl.ext_sel;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ALUOp     = ctrl.alu_op;
  assign RegDst    = ctrl.reg_dst;
  assign RegWre    = ctrl.reg_wre;
  assign DBDataSrc = ctrl.db_data_src;
  assign mRD       = ctrl.m_rd;
  assign mWR       = ctrl.m_wr;
  assign PCSrc     = ctrl.pc_src;
  assign state     = st;

endmodule
